// File: rtl/runtime_ctr_bank.sv
// runtime_ctr_bank: bank of independent start/stop cycle counters with a registered, muxed read port.
// Define TPU_CTR_SNAPSHOT_EN to add a snap strobe that freezes all channels into shadow registers for readout.
module runtime_ctr_bank #(
    parameter int NUM_CH    = 4,
    parameter int CTR_WIDTH = 32,
    parameter int SATURATE  = 0,
    localparam int SEL_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    start,
    input  logic [NUM_CH-1:0]    stop,
    input  logic [NUM_CH-1:0]    clr_ovf,
    input  logic [SEL_W-1:0]     rd_sel,
`ifdef TPU_CTR_SNAPSHOT_EN
    input  logic                 snap,
`endif
    output logic [CTR_WIDTH-1:0] rd_data,
    output logic                 rd_ovf,
    output logic [NUM_CH-1:0]    running
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t               state   [NUM_CH];
    logic [CTR_WIDTH-1:0] cnt     [NUM_CH];
    logic                 ovf     [NUM_CH];
    logic [CTR_WIDTH-1:0] cnt_nxt [NUM_CH];
    logic                 wrap    [NUM_CH];
    logic [CTR_WIDTH-1:0] src_cnt [NUM_CH];
    logic                 src_ovf [NUM_CH];
    logic [CTR_WIDTH-1:0] sel_cnt;
    logic                 sel_ovf;

    // Returns {overflow, next}; an increment from all-ones either wraps or holds.
    function automatic logic [CTR_WIDTH:0] incr_sat(input logic [CTR_WIDTH-1:0] v);
        logic [CTR_WIDTH-1:0] nv;
        if (&v) begin
            nv = (SATURATE != 0) ? v : {CTR_WIDTH{1'b0}};
            return {1'b1, nv};
        end
        return {1'b0, v + CTR_WIDTH'(1)};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            {wrap[i], cnt_nxt[i]} = incr_sat(cnt[i]);
            running[i] = (state[i] == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
                ovf[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                case (state[i])
                    IDLE: begin
                        if (start[i] && !stop[i]) begin
                            state[i] <= RUN;
                            cnt[i]   <= '0;
                            ovf[i]   <= 1'b0;
                        end else if (clr_ovf[i]) begin
                            ovf[i] <= 1'b0;
                        end
                    end
                    RUN: begin
                        // The stop edge still counts; a second start is ignored.
                        cnt[i] <= cnt_nxt[i];
                        if (wrap[i])
                            ovf[i] <= 1'b1;
                        else if (clr_ovf[i])
                            ovf[i] <= 1'b0;
                        if (stop[i])
                            state[i] <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TPU_CTR_SNAPSHOT_EN
    logic [CTR_WIDTH-1:0] shadow_cnt [NUM_CH];
    logic                 shadow_ovf [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_cnt[i] <= '0;
                shadow_ovf[i] <= 1'b0;
            end
        end else if (snap) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_cnt[i] <= cnt[i];
                shadow_ovf[i] <= ovf[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            src_cnt[i] = shadow_cnt[i];
            src_ovf[i] = shadow_ovf[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            src_cnt[i] = cnt[i];
            src_ovf[i] = ovf[i];
        end
    end
`endif

    // Out-of-range selects match no channel and read back zero.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_cnt = src_cnt[i];
                sel_ovf = src_ovf[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_ovf  <= 1'b0;
        end else begin
            rd_data <= sel_cnt;
            rd_ovf  <= sel_ovf;
        end
    end

endmodule

// File: tb/tb_runtime_ctr_bank.sv
// Bench for runtime_ctr_bank: wrapping and saturating instances side by side against an elapsed-cycle model.
// Build with TPU_CTR_SNAPSHOT_EN defined to cover the snapshot readout path.
module tb_runtime_ctr_bank;
    localparam int NCH  = 3;
    localparam int W    = 5;
    localparam int MOD  = 32;
    localparam int MAXV = 31;
`ifdef TPU_CTR_SNAPSHOT_EN
    localparam bit SNAP_EN = 1'b1;
`else
    localparam bit SNAP_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] start = '0, stop = '0, clr_ovf = '0;
    logic [1:0]     rd_sel = '0;
    logic           snap = 1'b1;
    logic [W-1:0]   rd_data0, rd_data1;
    logic           rd_ovf0, rd_ovf1;
    logic [NCH-1:0] running0, running1;
    logic [W-1:0]   rdd [2];
    logic           rdo [2];
    logic [NCH-1:0] rnr [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    runtime_ctr_bank #(.NUM_CH(NCH), .CTR_WIDTH(W), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr_ovf(clr_ovf), .rd_sel(rd_sel),
`ifdef TPU_CTR_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_data(rd_data0), .rd_ovf(rd_ovf0), .running(running0));

    runtime_ctr_bank #(.NUM_CH(NCH), .CTR_WIDTH(W), .SATURATE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clr_ovf(clr_ovf), .rd_sel(rd_sel),
`ifdef TPU_CTR_SNAPSHOT_EN
        .snap(snap),
`endif
        .rd_data(rd_data1), .rd_ovf(rd_ovf1), .running(running1));

    assign rdd[0] = rd_data0;
    assign rdd[1] = rd_data1;
    assign rdo[0] = rd_ovf0;
    assign rdo[1] = rd_ovf1;
    assign rnr[0] = running0;
    assign rnr[1] = running1;

    // Model: a channel's value is the number of edges elapsed since its start edge,
    // folded by wrap (m=0) or clamp (m=1). Overflow is judged from that elapsed count.
    int             e = 0;
    bit             m_run [NCH];
    int             m_t0  [NCH];
    int             m_t1  [NCH];
    bit             m_ovf [2][NCH];
    int             sh_val [2][NCH];
    bit             sh_ovf [2][NCH];
    int             exp_data [2];
    bit             exp_ovf  [2];
    logic [NCH-1:0] exp_run;

    function automatic int model_val(int m, int ch);
        int el;
        el = (m_run[ch] ? e : m_t1[ch]) - m_t0[ch];
        if (m == 1) return (el > MAXV) ? MAXV : el;
        return el % MOD;
    endfunction

    task automatic step();
        int pre_val [2][NCH];
        bit pre_ovf [2][NCH];
        int el_before;
        bit hit;
        for (int m = 0; m < 2; m++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                pre_val[m][ch] = model_val(m, ch);
                pre_ovf[m][ch] = m_ovf[m][ch];
            end
            if (rd_sel < NCH) begin
                exp_data[m] = SNAP_EN ? sh_val[m][rd_sel] : pre_val[m][rd_sel];
                exp_ovf[m]  = SNAP_EN ? sh_ovf[m][rd_sel] : pre_ovf[m][rd_sel];
            end else begin
                exp_data[m] = 0;
                exp_ovf[m]  = 1'b0;
            end
        end
        @(posedge clk);
        e++;
        if (rst) begin
            for (int ch = 0; ch < NCH; ch++) begin
                m_run[ch] = 1'b0;
                m_t0[ch]  = e;
                m_t1[ch]  = e;
                for (int m = 0; m < 2; m++) begin
                    m_ovf[m][ch]  = 1'b0;
                    sh_val[m][ch] = 0;
                    sh_ovf[m][ch] = 1'b0;
                end
            end
            for (int m = 0; m < 2; m++) begin
                exp_data[m] = 0;
                exp_ovf[m]  = 1'b0;
            end
        end else begin
            if (snap && SNAP_EN) begin
                for (int m = 0; m < 2; m++)
                    for (int ch = 0; ch < NCH; ch++) begin
                        sh_val[m][ch] = pre_val[m][ch];
                        sh_ovf[m][ch] = pre_ovf[m][ch];
                    end
            end
            for (int ch = 0; ch < NCH; ch++) begin
                if (m_run[ch]) begin
                    el_before = e - 1 - m_t0[ch];
                    for (int m = 0; m < 2; m++) begin
                        hit = (m == 1) ? (el_before >= MAXV) : ((el_before % MOD) == MAXV);
                        if (hit) m_ovf[m][ch] = 1'b1;
                        else if (clr_ovf[ch]) m_ovf[m][ch] = 1'b0;
                    end
                    if (stop[ch]) begin
                        m_run[ch] = 1'b0;
                        m_t1[ch]  = e;
                    end
                end else if (start[ch] && !stop[ch]) begin
                    m_run[ch] = 1'b1;
                    m_t0[ch]  = e;
                    m_ovf[0][ch] = 1'b0;
                    m_ovf[1][ch] = 1'b0;
                end else if (clr_ovf[ch]) begin
                    m_ovf[0][ch] = 1'b0;
                    m_ovf[1][ch] = 1'b0;
                end
            end
        end
        for (int ch = 0; ch < NCH; ch++) exp_run[ch] = m_run[ch];
        @(negedge clk);
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        steps(2);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rdd[m] !== '0 || rdo[m] !== 1'b0 || rnr[m] !== '0) begin
                bad++;
                $display("FAIL reset dut%0d data=%0d ovf=%0d running=%b want 0/0/000", m, rdd[m], rdo[m], rnr[m]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        steps(9);
        start = 3'b001;
        step();
        start = '0;
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rnr[m][0] !== 1'b1) begin
                bad++; $display("FAIL basic_run_first dut%0d running0=%0d want 1", m, rnr[m][0]);
            end
        end
        steps(14);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rnr[m][0] !== 1'b1) begin
                bad++; $display("FAIL basic_run_last dut%0d running0=%0d want 1", m, rnr[m][0]);
            end
        end
        stop = 3'b001;
        step();
        stop = '0;
        rd_sel = 2'd0;
        steps(3);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rnr[m][0] !== 1'b0 || rdd[m] !== W'(15) || rdo[m] !== 1'b0) begin
                bad++;
                $display("FAIL basic_result dut%0d run=%0d data=%0d ovf=%0d want 0/15/0", m, rnr[m][0], rdd[m], rdo[m]);
            end
        end
    endtask

    task automatic test_restart_ignore();
        start = 3'b110;
        stop  = 3'b100;
        step();
        start = '0; stop = '0;
        steps(2);
        start = 3'b010;
        step();
        start = '0;
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rnr[m][2:1] !== 2'b01) begin
                bad++; $display("FAIL restart_state dut%0d running=%b want x01 in [2:1]", m, rnr[m]);
            end
        end
        steps(3);
        stop = 3'b010;
        step();
        stop = '0;
        rd_sel = 2'd1;
        steps(3);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rdd[m] !== W'(7) || rnr[m] !== '0) begin
                bad++; $display("FAIL restart_ch1 dut%0d data=%0d running=%b want 7/000", m, rdd[m], rnr[m]);
            end
        end
        rd_sel = 2'd2;
        steps(3);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rdd[m] !== '0 || rdo[m] !== 1'b0) begin
                bad++; $display("FAIL start_stop_idle dut%0d data=%0d ovf=%0d want 0/0", m, rdd[m], rdo[m]);
            end
        end
    endtask

    task automatic test_overflow();
        int want [2];
        want[0] = 40 % MOD;
        want[1] = MAXV;
        rd_sel = 2'd0;
        start = 3'b001;
        step();
        start = '0;
        steps(39);
        stop = 3'b001;
        step();
        stop = '0;
        steps(3);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rdd[m] !== W'(want[m]) || rdo[m] !== 1'b1) begin
                bad++; $display("FAIL overflow dut%0d data=%0d ovf=%0d want %0d/1", m, rdd[m], rdo[m], want[m]);
            end
        end
        clr_ovf = 3'b001;
        step();
        clr_ovf = '0;
        steps(3);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rdd[m] !== W'(want[m]) || rdo[m] !== 1'b0) begin
                bad++; $display("FAIL clr_ovf dut%0d data=%0d ovf=%0d want %0d/0", m, rdd[m], rdo[m], want[m]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        start = 3'b111;
        step();
        start = '0;
        steps(6);
        rst = 1'b1;
        start = 3'b111;
        step();
        rst = 1'b0;
        start = '0;
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rnr[m] !== '0 || rdd[m] !== '0 || rdo[m] !== 1'b0) begin
                bad++; $display("FAIL reset_midrun dut%0d running=%b data=%0d ovf=%0d want 000/0/0", m, rnr[m], rdd[m], rdo[m]);
            end
        end
        start = 3'b001;
        step();
        start = '0;
        steps(4);
        stop = 3'b001;
        step();
        stop = '0;
        rd_sel = 2'd0;
        steps(3);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rdd[m] !== W'(5)) begin
                bad++; $display("FAIL after_reset dut%0d data=%0d want 5", m, rdd[m]);
            end
        end
    endtask

    task automatic test_sel_oob();
        rd_sel = 2'd3;
        steps(2);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rdd[m] !== '0 || rdo[m] !== 1'b0) begin
                bad++; $display("FAIL sel_oob dut%0d data=%0d ovf=%0d want 0/0", m, rdd[m], rdo[m]);
            end
        end
    endtask

`ifdef TPU_CTR_SNAPSHOT_EN
    task automatic test_snapshot();
        snap = 1'b0;
        rd_sel = 2'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        start = 3'b001;
        step();
        start = '0;
        steps(20);
        snap = 1'b1;
        step();
        snap = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            for (int m = 0; m < 2; m++) begin
                total++;
                if (rdd[m] !== W'(20) || rnr[m][0] !== 1'b1) begin
                    bad++; $display("FAIL snap_hold dut%0d data=%0d run=%0d want 20/1", m, rdd[m], rnr[m][0]);
                end
            end
        end
        steps(3);
        snap = 1'b1;
        step();
        snap = 1'b0;
        steps(2);
        for (int m = 0; m < 2; m++) begin
            total++;
            if (rdd[m] !== W'(30)) begin
                bad++; $display("FAIL snap_second dut%0d data=%0d want 30", m, rdd[m]);
            end
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            rst     = ($urandom_range(0, 99) == 0);
            start   = '0; stop = '0; clr_ovf = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                start[ch]   = ($urandom_range(0, 5) == 0);
                stop[ch]    = ($urandom_range(0, 19) == 0);
                clr_ovf[ch] = ($urandom_range(0, 15) == 0);
            end
            rd_sel = 2'($urandom_range(0, 3));
            snap   = ($urandom_range(0, 3) == 0);
            step();
            for (int m = 0; m < 2; m++) begin
                total++;
                if (rdd[m] !== W'(exp_data[m]) || rdo[m] !== exp_ovf[m] || rnr[m] !== exp_run) begin
                    bad++;
                    $display("FAIL random cyc=%0d dut%0d data=%0d ovf=%0d run=%b want %0d/%0d/%b",
                             k, m, rdd[m], rdo[m], rnr[m], exp_data[m], exp_ovf[m], exp_run);
                end
            end
        end
        rst = 1'b0; start = '0; stop = '0; clr_ovf = '0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_restart_ignore();
        test_overflow();
        test_reset_midrun();
        test_sel_oob();
`ifdef TPU_CTR_SNAPSHOT_EN
        test_snapshot();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/runtime_ctr_bank.md
Name: runtime_ctr_bank

Overview:
Multi-channel cycle counter bank: successor to the single-channel runtime counter, generalised in channel count, counter width and overflow mode.
Each channel measures cycles between its own start/stop events (instruction issue to synchronisation, per unit).
It sits beside the control unit and feeds a registered, muxed read port to the host/register interface.
Optional global snapshot freezes all channels coherently for readout.

Parameters:
NUM_CH, 4, number of independent counter channels (>=1)
CTR_WIDTH, 32, counter width in bits (>=2)
SATURATE, 0, 0 = wrap at 2^CTR_WIDTH, 1 = hold at all-ones

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  NUM_CH  per-channel start pulse (instruction enable)
stop  in  NUM_CH  per-channel stop pulse (synch)
clr_ovf  in  NUM_CH  per-channel clear of sticky overflow flag
rd_sel  in  $clog2(NUM_CH) (min 1)  channel select for readout
rd_data  out  CTR_WIDTH  registered counter value of selected channel
rd_ovf  out  1  registered overflow flag of selected channel
running  out  NUM_CH  per-channel state, 1 = RUN
snap  in  1  snapshot strobe (only with TPU_CTR_SNAPSHOT_EN; otherwise ignored/unconnected)

Behaviour:
- Reset (synchronous, active-high): all counters 0, all channels IDLE, overflow flags 0, rd_data 0, rd_ovf 0, running 0, shadow registers 0. Reset has priority over every other input, including mid-run.
- Per-channel FSM, states IDLE/RUN; inputs sampled at each rising edge:
  - IDLE, start=1, stop=0: counter <= 0, overflow flag <= 0, go to RUN.
  - IDLE, stop=1 (either value of start): stay IDLE, counter held.
  - IDLE, start=0, stop=0: hold.
  - RUN, stop=1 (either value of start): counter increments on this edge, go to IDLE.
  - RUN, start=1, stop=0: ignored, keep counting, no restart.
  - RUN, no event: counter increments.
- Result: with start at edge N and stop at edge M, the held value is M-N.
- Overflow:
  - Increment from all-ones sets the sticky ovf flag.
  - SATURATE=0: counter wraps to 0.
  - SATURATE=1: counter stays all-ones.
  - ovf is cleared by clr_ovf[i], by a new start, or by reset.
  - If clr_ovf and an overflowing increment occur in the same cycle, set wins.
- Channels are fully independent. Simultaneous events on different channels are all honoured in the same cycle.
- Readout:
  - rd_data/rd_ovf <= value[rd_sel]/ovf[rd_sel] as held before the edge; one-cycle latency.
  - rd_sel >= NUM_CH returns 0.
- running[i] is the registered state bit, 1 in the cycle after the start edge.

Optional Feature:
TPU_CTR_SNAPSHOT_EN
- Defined:
  - snap=1 at an edge copies all NUM_CH counters and ovf flags into shadow registers in the same cycle, using pre-edge values.
  - Readout sources the shadow registers only.
  - Counting is unaffected.
  - snap during reset: reset wins.
- Undefined: no shadow registers, snap port absent, readout sources live counters.

Test Plan:
- Reset, start[0] at cycle 10, stop[0] at cycle 25, rd_sel=0 -> rd_data=15 from cycle 27 onward; running[0]=1 in cycles 11..25.
- Channel 1: start at 5, extra start at 8, stop at 12; channel 2: start and stop together at 5 while IDLE -> ch1=7, ch2 stays IDLE with value 0.
- CTR_WIDTH=4: run 20 cycles -> SATURATE=0 gives 4 with rd_ovf=1; SATURATE=1 gives 15 with rd_ovf=1; clr_ovf pulse -> rd_ovf=0 and value unchanged.
- Assert rst at cycle 7 of a run on all channels -> next cycle all counters 0, running=0, rd_data=0; later start behaves normally.
- TPU_CTR_SNAPSHOT_EN: ch0 runs from cycle 0, snap at cycle 20 -> rd_data stays 20 while live counting continues; second snap at 30 -> 30.
- rd_sel=NUM_CH (NUM_CH=3, sel=3) -> rd_data=0, rd_ovf=0.
